// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Index/tag widths below describe the default 32-line build.
package dcache_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int WSEL_W   = 3;
  localparam int INDEX_W  = 5;
  localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS,
    ST_WRITEBACK,
    ST_READMISS,
    ST_READMISSOK
  } state_e;

  function automatic logic [LINE_W-1:0] merge_word(
    input logic [LINE_W-1:0] line,
    input logic [WSEL_W-1:0] sel,
    input logic [WORD_W-1:0] word
  );
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[32'(sel)*WORD_W +: WORD_W] = word;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the data cache: valid/dirty bits, tags and 256-bit data.
// Asynchronous read port, single write port committed on the rising edge.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES = 32,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_L = ADDR_W - OFFSET_W - IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic              o_rd_dirty,
  output logic [TAG_L-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_data,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic              i_wr_valid,
  input  logic              i_wr_dirty,
  input  logic [TAG_L-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_data
);

  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_L-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= i_wr_valid;
      r_dirty[i_wr_idx] <= i_wr_dirty;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid=0 makes their contents don't-care
  // and keeps them mappable onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
`endif
  input  logic [LINE_W-1:0] mem_data_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_L = ADDR_W - OFFSET_W - IDX_W;

  state_e r_state, w_next;

  logic [IDX_W-1:0]  w_index;
  logic [TAG_L-1:0]  w_tag;
  logic [WSEL_W-1:0] w_word;
  logic              w_req, w_hit;
  logic              w_rd_valid, w_rd_dirty;
  logic [TAG_L-1:0]  w_rd_tag;
  logic [LINE_W-1:0] w_rd_data;
  logic              w_we, w_wr_dirty;
  logic [LINE_W-1:0] w_wr_data;
  logic              w_unused_addr;

  assign w_index       = cpu_addr_i[OFFSET_W +: IDX_W];
  assign w_tag         = cpu_addr_i[ADDR_W-1 -: TAG_L];
  assign w_word        = cpu_addr_i[OFFSET_W-1:2];
  assign w_unused_addr = ^cpu_addr_i[1:0];

  assign w_req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_hit      = w_req & w_rd_valid & (w_rd_tag == w_tag);
  assign cpu_data_o = w_hit ? w_rd_data[32'(w_word)*WORD_W +: WORD_W] : '0;
  assign mem_data_o = w_rd_data;

  dcache_sram #(.LINES(LINES)) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_rd_idx   (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_dirty (w_rd_dirty),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_we       (w_we),
    .i_wr_idx   (w_index),
    .i_wr_valid (1'b1),
    .i_wr_dirty (w_wr_dirty),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_wr_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (w_req && !w_hit) w_next = ST_MISS;
      ST_MISS:       w_next = (w_rd_valid && w_rd_dirty) ? ST_WRITEBACK : ST_READMISS;
      ST_WRITEBACK:  if (mem_ack_i) w_next = ST_READMISS;
      ST_READMISS:   if (mem_ack_i) w_next = ST_READMISSOK;
      ST_READMISSOK: w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  // Line writes happen for a write hit in IDLE and for the refill in READMISSOK;
  // simultaneous read+write is handled as a write.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    cpu_stall_o  = (r_state != ST_IDLE) | (w_req & ~w_hit);
    w_we         = 1'b0;
    w_wr_dirty   = 1'b0;
    w_wr_data    = mem_data_i;
    case (r_state)
      ST_IDLE: begin
        if (w_hit && cpu_MemWrite_i) begin
          w_we       = 1'b1;
          w_wr_dirty = 1'b1;
          w_wr_data  = merge_word(w_rd_data, w_word, cpu_data_i);
        end
      end
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {w_rd_tag, w_index, {OFFSET_W{1'b0}}};
      end
      ST_READMISS:   mem_enable_o = 1'b1;
      ST_READMISSOK: w_we = 1'b1;
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        r_replay;
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // The IDLE cycle right after a refill is the replay of a counted miss.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_replay   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_replay <= (r_state == ST_READMISSOK);
      if (r_state == ST_IDLE && w_req && !r_replay) begin
        if (w_hit) begin
          if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: scoreboarded CPU accesses against
// a line-based memory model that acknowledges on the 9th enabled cycle.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i, cpu_data_i;
  logic         cpu_MemRead_i, cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [255:0] mem_data_i;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_op_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  mem_op_t      exp_mem[$];
  int           exp_stall[$];
  logic [31:0]  exp_rdata[$];
  logic [255:0] mem_model [2048];
  int           ack_cnt;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] default_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = ({a[31:5], 5'b0} + 32'(w*4)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [255:0] with_word(input logic [255:0] l, input int w, input logic [31:0] v);
    logic [255:0] r;
    r = l;
    r[w*32 +: 32] = v;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mem_model[i] = default_line(32'(i) << 5);
  end

  // Memory: ack on the 9th consecutive enabled cycle, registered read data.
  assign mem_ack_i = mem_enable_o && (ack_cnt == 8);

  always @(posedge clk_i) begin
    if (mem_enable_o) ack_cnt <= mem_ack_i ? 0 : ack_cnt + 1;
    else              ack_cnt <= 0;
    mem_data_i <= mem_model[mem_addr_o[15:5]];
    if (mem_enable_o && mem_ack_i) begin
      if (mem_write_o) mem_model[mem_addr_o[15:5]] <= mem_data_o;
      if (exp_mem.size() == 0) begin
        check("mem_unexpected_op", {224'b0, mem_addr_o}, '1);
      end else begin
        mem_op_t e;
        e = exp_mem.pop_front();
        check("mem_op_write", mem_write_o, e.wr);
        check("mem_op_addr", mem_addr_o, e.addr);
        if (e.wr) check("mem_op_data", mem_data_o, e.data);
      end
    end
  end

  task automatic exp_op(input logic wr, input logic [31:0] addr, input logic [255:0] data);
    mem_op_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    exp_mem.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the access completes.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall, input logic [31:0] rdata);
    int n;
    logic [31:0] obs;
    exp_stall.push_back(stall);
    if (rd && !wr) exp_rdata.push_back(rdata);
    cpu_addr_i = addr; cpu_data_i = wdata;
    cpu_MemRead_i = rd; cpu_MemWrite_i = wr;
    n = 0;
    @(negedge clk_i);
    while (cpu_stall_o && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    if (n == 40) check("stall_timeout", 1, 0);
    obs = cpu_data_o;
    @(posedge clk_i); #1;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    check("stall_cycles", 256'(n), 256'(exp_stall.pop_front()));
    if (rd && !wr) check("read_data", obs, exp_rdata.pop_front());
  endtask

  initial begin
    int n;
    rst_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_mem_enable", mem_enable_o, 0);
    check("rst_mem_write", mem_write_o, 0);
    check("rst_stall", cpu_stall_o, 0);
    check("rst_cpu_data", cpu_data_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Clean read miss, then hits on the refilled line.
    exp_op(1'b0, 32'h0000_0000, '0);
    access(1, 0, 32'h0000_0004, 0, 12, 32'h5A5A_0004);
    access(0, 1, 32'h0000_0008, 32'hDEAD_BEEF, 0, 0);
    access(1, 0, 32'h0000_0008, 0, 0, 32'hDEAD_BEEF);
    access(1, 0, 32'h0000_0000, 0, 0, 32'h5A5A_0000);

    // Dirty victim: writeback of merged line, then refill.
    exp_op(1'b1, 32'h0000_0000, with_word(default_line(32'h0), 2, 32'hDEAD_BEEF));
    exp_op(1'b0, 32'h0000_0400, '0);
    access(1, 0, 32'h0000_0400, 0, 21, 32'h5A5A_0400);

    // Write miss allocates, merges, and leaves the line dirty.
    exp_op(1'b0, 32'h0000_0820, '0);
    access(0, 1, 32'h0000_0820, 32'h1234_5678, 12, 0);
    access(1, 0, 32'h0000_0820, 0, 0, 32'h1234_5678);
    exp_op(1'b1, 32'h0000_0820, with_word(default_line(32'h820), 0, 32'h1234_5678));
    exp_op(1'b0, 32'h0000_0C20, '0);
    access(1, 0, 32'h0000_0C20, 0, 21, 32'h5A5A_0C20);

    // Read and write together act as a write.
    access(1, 1, 32'h0000_0404, 32'hCAFE_F00D, 0, 0);
    access(1, 0, 32'h0000_0404, 0, 0, 32'hCAFE_F00D);

    // Reset in the middle of a refill abandons it.
    cpu_addr_i = 32'h0000_1040; cpu_MemRead_i = 1'b1;
    n = 0;
    while (!mem_enable_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("readmiss_reached", mem_enable_o, 1);
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_mem_enable", mem_enable_o, 0);
    check("midrst_mem_write", mem_write_o, 0);
    cpu_MemRead_i = 1'b0;
    #1;
    check("midrst_stall", cpu_stall_o, 0);
    check("midrst_cpu_data", cpu_data_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    exp_op(1'b0, 32'h0000_1040, '0);
    access(1, 0, 32'h0000_1040, 0, 12, 32'h5A5A_1040);
    // Dirty bit was cleared by reset: no writeback, memory copy unchanged.
    exp_op(1'b0, 32'h0000_0400, '0);
    access(1, 0, 32'h0000_0404, 0, 12, 32'h5A5A_0404);

    repeat (2) @(posedge clk_i);
    check("mem_ops_outstanding", 256'(exp_mem.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
